// File: rtl/p_predict_serial.sv
// p_predict_serial: computes P' = F*P*F^T + Q for a 2-state filter, with F = [[1,dt],[0,1]], using one multiplier shared over cycles.
module p_predict_serial #(
    parameter int N    = 16,
    parameter int FRAC = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] dt,
    input  logic signed [N-1:0] P11,
    input  logic signed [N-1:0] P12,
    input  logic signed [N-1:0] P21,
    input  logic signed [N-1:0] P22,
    input  logic signed [N-1:0] Q11,
    input  logic signed [N-1:0] Q12,
    input  logic signed [N-1:0] Q21,
    input  logic signed [N-1:0] Q22,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] Pp11,
    output logic signed [N-1:0] Pp12,
    output logic signed [N-1:0] Pp21,
    output logic signed [N-1:0] Pp22
);
    localparam logic [2:0] IDLE = 3'd0, M1 = 3'd1, M2 = 3'd2, M3 = 3'd3, SUM = 3'd4;
    localparam int W = 2 * N + 2;
    localparam logic signed [W-1:0]   HALF = W'(1) <<< (FRAC - 1);
    localparam logic signed [W-1:0]   MAXW = (W'(1) <<< (N - 1)) - W'(1);
    localparam logic signed [W-1:0]   MINW = -(W'(1) <<< (N - 1));
    localparam logic signed [N+2:0]   MAX3 = (N+3)'((1 << (N - 1)) - 1);
    localparam logic signed [N+2:0]   MIN3 = -(N+3)'(1 << (N - 1));
    localparam logic signed [N-1:0]   MAXN = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]   MINN = {1'b1, {(N-1){1'b0}}};

    logic [2:0] state;
    logic signed [N-1:0] dt_r, p11, p12, p21, p22, q11, q12, q21, q22, t1, s, t3;
    logic signed [N:0]   mb;
    logic signed [W-1:0] prod, rnd;
    logic signed [N-1:0] fx;

    function automatic logic signed [N+2:0] x3(input logic signed [N-1:0] v);
        return {{3{v[N-1]}}, v};
    endfunction

    function automatic logic signed [N-1:0] sat3(input logic signed [N+2:0] v);
        return v > MAX3 ? MAXN : v < MIN3 ? MINN : v[N-1:0];
    endfunction

    // The P12+P21 addend keeps its carry bit so the multiply sees the exact sum.
    always_comb begin
        mb   = state == M1 ? {p22[N-1], p22} : state == M2 ? {p12[N-1], p12} + {p21[N-1], p21} : {t1[N-1], t1};
        prod = $signed({{(N+2){dt_r[N-1]}}, dt_r}) * $signed({{(N+1){mb[N]}}, mb});
        rnd  = (prod + HALF) >>> FRAC;
        fx   = rnd > MAXW ? MAXN : rnd < MINW ? MINN : rnd[N-1:0];
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            {dt_r, p11, p12, p21, p22, q11, q12, q21, q22} <= '0;
            {t1, s, t3} <= '0;
            {Pp11, Pp12, Pp21, Pp22} <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                {dt_r, p11, p12, p21, p22} <= {dt, P11, P12, P21, P22};
                {q11, q12, q21, q22} <= {Q11, Q12, Q21, Q22};
                state <= M1;
            end
            if (state == M1) begin
                t1    <= fx;
                state <= M2;
            end
            if (state == M2) begin
                s     <= fx;
                state <= M3;
            end
            if (state == M3) begin
                t3    <= fx;
                state <= SUM;
            end
            if (state == SUM) begin
                Pp11  <= sat3(x3(p11) + x3(s) + x3(t3) + x3(q11));
                Pp12  <= sat3(x3(p12) + x3(t1) + x3(q12));
                Pp21  <= sat3(x3(p21) + x3(t1) + x3(q21));
                Pp22  <= sat3(x3(p22) + x3(q22));
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end
endmodule
